sm83_mcycle_seq: RTL and testbench
==================================

// Module: sm83_mcycle_seq
// PURPOSE
//  Parametrised M-cycle/T-state sequencer. It replaces the fixed two-phase fetch/execute control in sm83_core.
//  Tracks T-states within each M-cycle and runs multi-M-cycle instructions using the length given by decode.
//  Handles the CB-prefix second fetch, conditional early termination, HALT/wake and memory wait-states.
//  Drives fetch_cycle/execute_cycle into core muxing (PC/IDU/address select), plus cycle indices for datapath sequencing.
// PARAMETERS
//  TCYC_PER_M  4  T-states per M-cycle (>=1)
//  MAX_MCYC    6  max execute M-cycles after fetch (>=1)
//  MC_W        $clog2(MAX_MCYC+1)  width of length/index fields
//  T_W         (TCYC_PER_M>1)?$clog2(TCYC_PER_M):1  tstate width
// PORTS
//  clk            in   1     core clock
//  rst_n          in   1     asynchronous active-low reset
//  dec_len        in   MC_W  execute M-cycles of decoded instr (0 = fetch-only, e.g. NOP)
//  dec_prefix     in   1     decoded opcode is 0xCB prefix
//  dec_halt       in   1     decoded opcode is HALT
//  cond_fail      in   1     branch condition false; end instruction at this M-cycle
//  irq_pending    in   1     (IE & IF) != 0
//  mem_ready      in   1     bus ready; low on last T-state stretches the M-cycle
//  fetch_cycle    out  1     current M-cycle is an opcode fetch (incl. prefix fetch)
//  prefix_cycle   out  1     current fetch is the CB second byte
//  execute_cycle  out  1     current M-cycle is an execute M-cycle
//  mcyc_idx       out  MC_W  execute M-cycle number, 1..len; 0 during fetch/halt
//  tstate         out  T_W   T-state within M-cycle
//  m_start        out  1     tstate==0
//  m_end          out  1     last T-state and mem_ready (advance point)
//  halted         out  1     in HALT state
//  len_err        out  1     1-cycle pulse: dec_len > MAX_MCYC sampled
//  pc_inhibit     out  1     suppress PC increment for this fetch (halt bug)
// BEHAVIOUR
//  - Reset (async, immediate, also mid-instruction): state=FETCH, tstate=0, mcyc_idx=0, len reg=0.
//    Outputs at reset: fetch_cycle=1, m_start=1. All other outputs 0, including m_end unless TCYC_PER_M==1.
//  - tstate: +1 per clk. Wraps to 0 after TCYC_PER_M-1 only if mem_ready=1; otherwise it holds at the last value.
//  - All state changes happen only on clk edges where m_end=1. Decode inputs are sampled only there.
//  - States: FETCH, PFETCH, EXEC, HALT. Outputs are decoded combinationally from the state registers.
//  - FETCH @m_end, priority order:
//    dec_halt&!irq_pending -> HALT
//    dec_halt&irq_pending  -> FETCH (no HALT entry)
//    dec_prefix            -> PFETCH
//    dec_len==0            -> FETCH
//    otherwise             -> EXEC, idx=1, len=min(dec_len,MAX_MCYC)
//  - PFETCH @m_end: as FETCH, but dec_prefix and dec_halt are ignored. A CB instruction never chains or halts.
//  - EXEC @m_end: if idx==len or cond_fail -> FETCH, idx=0; else idx+1.
//    cond_fail outside EXEC is ignored.
//  - HALT: fetch_cycle=execute_cycle=0, halted=1, tstate keeps counting.
//    @m_end with irq_pending -> FETCH. Wake latency is 1 M-cycle boundary.
//  - len_err pulses on any FETCH/PFETCH m_end where dec_len>MAX_MCYC. The length saturates; sequencing continues.
//  - fetch_cycle, execute_cycle and halted are mutually exclusive. Exactly one is 1 outside reset glitches.
//  - Latency: a decoded length N occupies N+1 M-cycles including its fetch. Fetch overlap is the core's concern.
// CONFIGURATION
//  SM83_HALT_BUG_EN defined:
//    dec_halt&irq_pending in FETCH -> next FETCH M-cycle has pc_inhibit=1 (byte fetched twice).
//    pc_inhibit clears at the end of that M-cycle.
//  SM83_HALT_BUG_EN undefined: pc_inhibit is tied to 0; transitions are otherwise identical.
// TESTING
//  1 Reset release, dec_len=0, TCYC_PER_M=4 -> fetch_cycle=1 always; m_end every 4th clk; mcyc_idx=0.
//  2 dec_len=3 at fetch m_end -> EXEC idx 1,2,3 (4 clk each), then FETCH; total 16 clk.
//  3 dec_len=5, cond_fail=1 at idx=2 m_end -> FETCH after idx 2; idx 3..5 never seen.
//  4 dec_prefix=1, then dec_len=2 -> FETCH, PFETCH (prefix_cycle=1), EXEC 1,2, FETCH.
//    A dec_prefix/dec_halt raised during PFETCH is ignored.
//  5 dec_halt=1, irq_pending=0 -> halted=1 for 3 M-cycles; irq_pending=1 -> FETCH at next m_end.
//    Also: dec_halt with irq_pending=1 -> no HALT; pc_inhibit=1 for 1 M-cycle only if SM83_HALT_BUG_EN.
//  6 mem_ready=0 for 3 clk at tstate=3 of EXEC idx 1 -> tstate holds at 3, m_end=0, idx holds.
//    dec_len=7 with MAX_MCYC=6 -> len_err pulse, 6 EXEC cycles.
//    rst_n low mid-EXEC -> immediate FETCH, tstate=0.

Source files
------------

// File: rtl/sm83_mcycle_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : sm83_mcycle_seq_if
// Purpose : Signal bundle between the decoder/core and the M-cycle
//           sequencer.
//   master : core side. Drives the decode and status inputs and receives
//            the sequencing outputs.
//   slave  : sequencer side.
//   Signals:
//     dec_len, dec_prefix, dec_halt, cond_fail, irq_pending, mem_ready
//       : core -> sequencer
//     fetch_cycle, prefix_cycle, execute_cycle, mcyc_idx, tstate, m_start,
//     m_end, halted, len_err, pc_inhibit
//       : sequencer -> core
//   MC_W and T_W must match the widths used by the sequencer instance.
// Revision: 1.0 - initial release
// ============================================================================
interface sm83_mcycle_seq_if #(
   parameter int MC_W = 3,
   parameter int T_W  = 2
);
   logic [MC_W-1:0] dec_len;
   logic            dec_prefix;
   logic            dec_halt;
   logic            cond_fail;
   logic            irq_pending;
   logic            mem_ready;

   logic            fetch_cycle;
   logic            prefix_cycle;
   logic            execute_cycle;
   logic [MC_W-1:0] mcyc_idx;
   logic [T_W-1:0]  tstate;
   logic            m_start;
   logic            m_end;
   logic            halted;
   logic            len_err;
   logic            pc_inhibit;

   modport master (
      output dec_len, dec_prefix, dec_halt, cond_fail, irq_pending, mem_ready,
      input  fetch_cycle, prefix_cycle, execute_cycle, mcyc_idx, tstate,
             m_start, m_end, halted, len_err, pc_inhibit
   );

   modport slave (
      input  dec_len, dec_prefix, dec_halt, cond_fail, irq_pending, mem_ready,
      output fetch_cycle, prefix_cycle, execute_cycle, mcyc_idx, tstate,
             m_start, m_end, halted, len_err, pc_inhibit
   );
endinterface
`default_nettype wire

// File: rtl/sm83_mcycle_seq.sv
`default_nettype none
// ============================================================================
// Module  : sm83_mcycle_seq
// Purpose : M-cycle / T-state sequencer for the SM83 core. It counts
//           T-states inside each M-cycle and steps through the fetch,
//           CB-prefix fetch, multi-cycle execute and HALT states. It also
//           stretches M-cycles on memory wait-states.
// Ports   :
//   clk    : core clock
//   rst_n  : asynchronous active-low reset
//   bus    : sm83_mcycle_seq_if.slave. It carries the decode and status
//            inputs and the cycle-control outputs.
// Config  : define SM83_HALT_BUG_EN to model the HALT bug. A HALT decoded
//           while an interrupt is already pending then raises pc_inhibit
//           for the following fetch M-cycle. Without the macro, pc_inhibit
//           is tied to 0.
// Revision: 1.0 - initial release
// ============================================================================
module sm83_mcycle_seq #(
   parameter int TCYC_PER_M = 4,
   parameter int MAX_MCYC   = 6,
   parameter int MC_W       = $clog2(MAX_MCYC + 1),
   parameter int T_W        = (TCYC_PER_M > 1) ? $clog2(TCYC_PER_M) : 1
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   sm83_mcycle_seq_if.slave   bus
);

   localparam logic [1:0]      c_FETCH  = 2'd0;
   localparam logic [1:0]      c_PFETCH = 2'd1;
   localparam logic [1:0]      c_EXEC   = 2'd2;
   localparam logic [1:0]      c_HALT   = 2'd3;

   localparam logic [T_W-1:0]  c_T_LAST = T_W'(TCYC_PER_M - 1);
   localparam logic [MC_W-1:0] c_MAX    = MC_W'(MAX_MCYC);

   logic [1:0]      r_state;
   logic [T_W-1:0]  r_tstate;
   logic [MC_W-1:0] r_idx;
   logic [MC_W-1:0] r_len;

   logic [1:0]      w_state_nx;
   logic [MC_W-1:0] w_idx_nx;
   logic [MC_W-1:0] w_len_nx;
   logic            w_last_t;
   logic            w_m_end;
   logic            w_len_over;
   logic [MC_W-1:0] w_len_sat;
   logic            w_halt_bug;

   // The last T-state only completes when the bus is ready. Otherwise the
   // whole M-cycle is stretched.
   assign w_last_t   = (r_tstate == c_T_LAST);
   assign w_m_end    = w_last_t & bus.mem_ready;
   assign w_len_over = (bus.dec_len > c_MAX);
   assign w_len_sat  = w_len_over ? c_MAX : bus.dec_len;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tstate <= '0;
      end else if (w_m_end) begin
         r_tstate <= '0;
      end else if (!w_last_t) begin
         r_tstate <= r_tstate + T_W'(1);
      end
   end

   // Next-state decode. Every transition is gated by the M-cycle boundary.
   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_len_nx   = r_len;
      w_halt_bug = 1'b0;
      if (w_m_end) begin
         case (r_state)
            c_FETCH, c_PFETCH: begin
               // A CB second byte can neither chain another prefix nor halt.
               if ((r_state == c_FETCH) && bus.dec_halt && !bus.irq_pending) begin
                  w_state_nx = c_HALT;
               end else if ((r_state == c_FETCH) && bus.dec_halt) begin
                  w_state_nx = c_FETCH;
                  w_halt_bug = 1'b1;
               end else if ((r_state == c_FETCH) && bus.dec_prefix) begin
                  w_state_nx = c_PFETCH;
               end else if (bus.dec_len == '0) begin
                  w_state_nx = c_FETCH;
               end else begin
                  w_state_nx = c_EXEC;
                  w_idx_nx   = MC_W'(1);
                  w_len_nx   = w_len_sat;
               end
            end
            c_EXEC: begin
               if ((r_idx == r_len) || bus.cond_fail) begin
                  w_state_nx = c_FETCH;
                  w_idx_nx   = '0;
               end else begin
                  w_idx_nx   = r_idx + MC_W'(1);
               end
            end
            default: begin
               if (bus.irq_pending) begin
                  w_state_nx = c_FETCH;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_FETCH;
         r_idx   <= '0;
         r_len   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_len   <= w_len_nx;
      end
   end

`ifdef SM83_HALT_BUG_EN
   logic r_pc_inhibit;

   // Set for exactly the fetch M-cycle that follows the HALT. It is
   // reloaded at that M-cycle's end, so it clears unless re-triggered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc_inhibit <= 1'b0;
      end else if (w_m_end) begin
         r_pc_inhibit <= w_halt_bug;
      end
   end

   assign bus.pc_inhibit = r_pc_inhibit;
`else
   logic w_halt_bug_unused;
   assign w_halt_bug_unused = w_halt_bug;
   assign bus.pc_inhibit    = 1'b0;
`endif

   assign bus.fetch_cycle   = (r_state == c_FETCH) || (r_state == c_PFETCH);
   assign bus.prefix_cycle  = (r_state == c_PFETCH);
   assign bus.execute_cycle = (r_state == c_EXEC);
   assign bus.halted        = (r_state == c_HALT);
   assign bus.mcyc_idx      = r_idx;
   assign bus.tstate        = r_tstate;
   assign bus.m_start       = (r_tstate == '0);
   assign bus.m_end         = w_m_end;
   assign bus.len_err       = w_m_end && w_len_over &&
                              ((r_state == c_FETCH) || (r_state == c_PFETCH));

endmodule
`default_nettype wire

// File: tb/tb_sm83_mcycle_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_sm83_mcycle_seq
// Purpose : Directed self-checking bench for sm83_mcycle_seq, configured
//           with TCYC_PER_M=4 and MAX_MCYC=6.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sm83_mcycle_seq;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   sm83_mcycle_seq_if #(.MC_W(3), .T_W(2)) bus ();

   sm83_mcycle_seq #(
      .TCYC_PER_M (4),
      .MAX_MCYC   (6)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Checks the state flags and the execute index in one call.
   task automatic chk_st(input string tag, input logic f, input logic e,
                         input logic h, input logic [2:0] idx);
      chk({tag, ".fetch"}, 32'(bus.fetch_cycle), 32'(f));
      chk({tag, ".exec"},  32'(bus.execute_cycle), 32'(e));
      chk({tag, ".halt"},  32'(bus.halted), 32'(h));
      chk({tag, ".idx"},   32'(bus.mcyc_idx), 32'(idx));
   endtask

   initial begin
      n_checks        = 0;
      n_errors        = 0;
      rst_n           = 1'b0;
      bus.dec_len     = 3'd0;
      bus.dec_prefix  = 1'b0;
      bus.dec_halt    = 1'b0;
      bus.cond_fail   = 1'b0;
      bus.irq_pending = 1'b0;
      bus.mem_ready   = 1'b1;

      // Reset state
      #3;
      chk_st("rst", 1'b1, 1'b0, 1'b0, 3'd0);
      chk("rst.m_start", 32'(bus.m_start), 32'd1);
      chk("rst.m_end",   32'(bus.m_end), 32'd0);
      chk("rst.tstate",  32'(bus.tstate), 32'd0);
      chk("rst.prefix",  32'(bus.prefix_cycle), 32'd0);
      chk("rst.len_err", 32'(bus.len_err), 32'd0);
      chk("rst.pc_inh",  32'(bus.pc_inhibit), 32'd0);
      tick(1);
      rst_n = 1'b1;

      // 1: fetch-only instructions, m_end on every 4th clk
      tick(3);
      chk("t1.tstate3", 32'(bus.tstate), 32'd3);
      chk("t1.m_end",   32'(bus.m_end), 32'd1);
      tick(1);
      chk_st("t1.wrap", 1'b1, 1'b0, 1'b0, 3'd0);
      chk("t1.m_start", 32'(bus.m_start), 32'd1);
      chk("t1.m_end0",  32'(bus.m_end), 32'd0);

      // 2: dec_len=3 -> EXEC 1,2,3, then FETCH after 16 clk in total
      bus.dec_len = 3'd3;
      tick(4);
      bus.dec_len = 3'd0;
      chk_st("t2.e1", 1'b0, 1'b1, 1'b0, 3'd1);
      tick(4);
      chk_st("t2.e2", 1'b0, 1'b1, 1'b0, 3'd2);
      tick(4);
      chk_st("t2.e3", 1'b0, 1'b1, 1'b0, 3'd3);
      tick(3);
      chk("t2.e3end", 32'(bus.m_end), 32'd1);
      tick(1);
      chk_st("t2.fetch", 1'b1, 1'b0, 1'b0, 3'd0);

      // 3: dec_len=5 with cond_fail at idx 2 -> back to FETCH
      bus.dec_len = 3'd5;
      tick(4);
      bus.dec_len = 3'd0;
      chk_st("t3.e1", 1'b0, 1'b1, 1'b0, 3'd1);
      tick(4);
      chk_st("t3.e2", 1'b0, 1'b1, 1'b0, 3'd2);
      bus.cond_fail = 1'b1;
      tick(4);
      chk_st("t3.early", 1'b1, 1'b0, 1'b0, 3'd0);
      // cond_fail held high through a fetch must not matter
      bus.dec_len = 3'd2;
      tick(4);
      bus.cond_fail = 1'b0;
      bus.dec_len   = 3'd0;
      chk_st("t3.cf_fetch", 1'b0, 1'b1, 1'b0, 3'd1);
      tick(4);
      chk_st("t3.cf_e2", 1'b0, 1'b1, 1'b0, 3'd2);
      tick(4);
      chk_st("t3.cf_done", 1'b1, 1'b0, 1'b0, 3'd0);

      // 4: CB prefix, then dec_len=2. Prefix/halt during PFETCH are ignored.
      bus.dec_prefix = 1'b1;
      tick(4);
      chk_st("t4.pf", 1'b1, 1'b0, 1'b0, 3'd0);
      chk("t4.prefix", 32'(bus.prefix_cycle), 32'd1);
      bus.dec_halt = 1'b1;
      bus.dec_len  = 3'd2;
      tick(4);
      bus.dec_prefix = 1'b0;
      bus.dec_halt   = 1'b0;
      bus.dec_len    = 3'd0;
      chk_st("t4.e1", 1'b0, 1'b1, 1'b0, 3'd1);
      chk("t4.prefix0", 32'(bus.prefix_cycle), 32'd0);
      tick(4);
      chk_st("t4.e2", 1'b0, 1'b1, 1'b0, 3'd2);
      tick(4);
      chk_st("t4.fetch", 1'b1, 1'b0, 1'b0, 3'd0);

      // 5: HALT for 3 M-cycles, wake on irq
      bus.dec_halt = 1'b1;
      tick(4);
      bus.dec_halt = 1'b0;
      chk_st("t5.h1", 1'b0, 1'b0, 1'b1, 3'd0);
      tick(4);
      chk_st("t5.h2", 1'b0, 1'b0, 1'b1, 3'd0);
      tick(2);
      chk("t5.h_tstate", 32'(bus.tstate), 32'd2);
      tick(2);
      chk_st("t5.h3", 1'b0, 1'b0, 1'b1, 3'd0);
      bus.irq_pending = 1'b1;
      tick(3);
      chk("t5.h3_last", 32'(bus.halted), 32'd1);
      tick(1);
      chk_st("t5.wake", 1'b1, 1'b0, 1'b0, 3'd0);
      // HALT with an interrupt already pending: no HALT entry
      bus.dec_halt = 1'b1;
      tick(4);
      bus.dec_halt    = 1'b0;
      bus.irq_pending = 1'b0;
      chk_st("t5.nohalt", 1'b1, 1'b0, 1'b0, 3'd0);
`ifdef SM83_HALT_BUG_EN
      chk("t5.pc_inh", 32'(bus.pc_inhibit), 32'd1);
`else
      chk("t5.pc_inh", 32'(bus.pc_inhibit), 32'd0);
`endif
      tick(4);
      chk("t5.pc_inh_clr", 32'(bus.pc_inhibit), 32'd0);
      chk_st("t5.after", 1'b1, 1'b0, 1'b0, 3'd0);

      // 6a: wait-states on the last T-state of EXEC idx 1
      bus.dec_len = 3'd1;
      tick(4);
      bus.dec_len = 3'd0;
      chk_st("t6.e1", 1'b0, 1'b1, 1'b0, 3'd1);
      tick(2);
      bus.mem_ready = 1'b0;
      tick(1);
      chk("t6.ws_t", 32'(bus.tstate), 32'd3);
      chk("t6.ws_mend", 32'(bus.m_end), 32'd0);
      tick(2);
      chk("t6.ws_hold", 32'(bus.tstate), 32'd3);
      chk("t6.ws_mend2", 32'(bus.m_end), 32'd0);
      chk_st("t6.ws_idx", 1'b0, 1'b1, 1'b0, 3'd1);
      bus.mem_ready = 1'b1;
      #1;
      chk("t6.ws_rel", 32'(bus.m_end), 32'd1);
      tick(1);
      chk_st("t6.ws_done", 1'b1, 1'b0, 1'b0, 3'd0);
      chk("t6.ws_t0", 32'(bus.tstate), 32'd0);

      // 6b: dec_len=7 saturates to 6 with a one-cycle len_err pulse
      bus.dec_len = 3'd7;
      tick(2);
      chk("t6.le_early", 32'(bus.len_err), 32'd0);
      tick(1);
      chk("t6.le_pulse", 32'(bus.len_err), 32'd1);
      tick(1);
      bus.dec_len = 3'd0;
      chk("t6.le_clear", 32'(bus.len_err), 32'd0);
      chk_st("t6.le_e1", 1'b0, 1'b1, 1'b0, 3'd1);
      tick(20);
      chk_st("t6.le_e6", 1'b0, 1'b1, 1'b0, 3'd6);
      tick(4);
      chk_st("t6.le_done", 1'b1, 1'b0, 1'b0, 3'd0);

      // 6c: asynchronous reset in the middle of EXEC
      bus.dec_len = 3'd3;
      tick(4);
      bus.dec_len = 3'd0;
      tick(5);
      chk_st("t6.pre_rst", 1'b0, 1'b1, 1'b0, 3'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_st("t6.rst", 1'b1, 1'b0, 1'b0, 3'd0);
      chk("t6.rst_t", 32'(bus.tstate), 32'd0);
      tick(1);
      rst_n = 1'b1;
      tick(3);
      chk("t6.post_t", 32'(bus.tstate), 32'd3);
      tick(1);
      chk_st("t6.post", 1'b1, 1'b0, 1'b0, 3'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
